// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

    localparam int unsigned RegW = 5;

    typedef logic [RegW-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        WAIT_D = 2'd1,
        HALTED = 2'd2
    } pipe_state_t;

    // One bundle of per-latch enable/flush controls.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic exmem_flush;
        logic memwb_en;
    } ctl_t;

    localparam ctl_t CtlHold = '0;

    localparam ctl_t CtlRun = '{
        pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
        default: 1'b0
    };

    // Every latch cleared, nothing advances.
    localparam ctl_t CtlReset = '{
        ifid_flush: 1'b1, idex_flush: 1'b1, exmem_flush: 1'b1,
        default: 1'b0
    };

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the sequencer (master) and the datapath (slave).
interface pipeline_ctrl_if #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 32
);
    logic             ihit;
    logic             dhit;
    logic             exmem_dREN;
    logic             exmem_dWEN;
    logic             idex_dREN;
    logic [REG_W-1:0] idex_regDst;
    logic [REG_W-1:0] ifid_rs;
    logic [REG_W-1:0] ifid_rt;
    logic             branch_taken;
    logic             jump;
    logic             halt_mem;

    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_en;
    logic             exmem_flush;
    logic             memwb_en;
    logic             halt;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] squash_cnt;

    modport master (
        input  ihit, dhit, exmem_dREN, exmem_dWEN, idex_dREN, idex_regDst, ifid_rs, ifid_rt,
               branch_taken, jump, halt_mem,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
               memwb_en, halt, cyc_cnt, stall_cnt, squash_cnt
    );

    modport slave (
        output ihit, dhit, exmem_dREN, exmem_dWEN, idex_dREN, idex_regDst, ifid_rs, ifid_rt,
               branch_taken, jump, halt_mem,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
               memwb_en, halt, cyc_cnt, stall_cnt, squash_cnt
    );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare: load in EX whose destination feeds an ID source.
module hazard_detect #(
    parameter int unsigned REG_W = 5
) (
    input  logic             idex_dren_i,
    input  logic [REG_W-1:0] idex_regdst_i,
    input  logic [REG_W-1:0] ifid_rs_i,
    input  logic [REG_W-1:0] ifid_rt_i,
    output logic             lu_o
);

    // r0 is hardwired zero, so a load targeting it never creates a dependency.
    always_comb begin
        lu_o = idex_dren_i && (idex_regdst_i != '0) &&
               ((idex_regdst_i == ifid_rs_i) || (idex_regdst_i == ifid_rt_i));
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Optional perf counters enabled by defining PIPE_PERF_EN.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 32
) (
    input  logic               CLK,
    input  logic               nRST,
    pipeline_ctrl_if.master    bus
);

    pipe_state_t state_q, state_d;
    logic        halt_q, halt_d;
    logic        lu;
    logic        mem_op;
    ctl_t        ctl;
    ctl_t        ctl_out;

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .idex_dren_i   (bus.idex_dREN),
        .idex_regdst_i (bus.idex_regDst),
        .ifid_rs_i     (bus.ifid_rs),
        .ifid_rt_i     (bus.ifid_rt),
        .lu_o          (lu)
    );

    assign mem_op = bus.exmem_dREN | bus.exmem_dWEN;

    // Priority resolution of stall/squash events and next-state selection.
    always_comb begin
        ctl     = CtlHold;
        state_d = state_q;
        halt_d  = halt_q;
        case (state_q)
            RUN, WAIT_D: begin
                if (state_q == WAIT_D && !bus.dhit) begin
                    ctl = CtlHold;
                end else if (mem_op && !bus.dhit) begin
                    ctl     = CtlHold;
                    state_d = WAIT_D;
                end else begin
                    // Reaching here with mem_op set implies dhit, in either state.
                    state_d = RUN;
                    if (mem_op && !bus.ihit) begin
                        ctl.memwb_en    = 1'b1;
                        ctl.exmem_flush = 1'b1;
                    end else if (!bus.ihit) begin
                        ctl = CtlHold;
                    end else if (bus.halt_mem) begin
                        ctl.memwb_en = 1'b1;
                        state_d      = HALTED;
                        halt_d       = 1'b1;
                    end else if (bus.branch_taken) begin
                        ctl            = CtlRun;
                        ctl.ifid_flush = 1'b1;
                        ctl.idex_flush = 1'b1;
                    end else if (lu) begin
                        ctl.idex_flush = 1'b1;
                        ctl.exmem_en   = 1'b1;
                        ctl.memwb_en   = 1'b1;
                    end else if (bus.jump) begin
                        ctl            = CtlRun;
                        ctl.ifid_flush = 1'b1;
                    end else begin
                        ctl = CtlRun;
                    end
                end
            end
            HALTED: ctl = CtlHold;
            default: state_d = RUN;
        endcase
    end

    // State and sticky halt flop.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
        end
    end

    // Reset forces every latch clear regardless of state.
    always_comb begin
        ctl_out = ctl;
        if (!nRST) begin
            ctl_out = CtlReset;
        end
    end

    assign bus.pc_en       = ctl_out.pc_en;
    assign bus.ifid_en     = ctl_out.ifid_en;
    assign bus.ifid_flush  = ctl_out.ifid_flush;
    assign bus.idex_en     = ctl_out.idex_en;
    assign bus.idex_flush  = ctl_out.idex_flush;
    assign bus.exmem_en    = ctl_out.exmem_en;
    assign bus.exmem_flush = ctl_out.exmem_flush;
    assign bus.memwb_en    = ctl_out.memwb_en;
    assign bus.halt        = halt_q;

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] squash_q, squash_d;

    // Counters freeze once halted; they wrap naturally.
    always_comb begin
        cyc_d    = cyc_q;
        stall_d  = stall_q;
        squash_d = squash_q;
        if (state_q != HALTED) begin
            cyc_d = cyc_q + CNT_W'(1);
            if (!ctl.pc_en) begin
                stall_d = stall_q + CNT_W'(1);
            end
            if (ctl.ifid_flush) begin
                squash_d = squash_q + CNT_W'(1);
            end
        end
    end

    // Perf counter flops.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cyc_q    <= '0;
            stall_q  <= '0;
            squash_q <= '0;
        end else begin
            cyc_q    <= cyc_d;
            stall_q  <= stall_d;
            squash_q <= squash_d;
        end
    end

    assign bus.cyc_cnt    = cyc_q;
    assign bus.stall_cnt  = stall_q;
    assign bus.squash_cnt = squash_q;
`else
    assign bus.cyc_cnt    = {CNT_W{1'b0}};
    assign bus.stall_cnt  = {CNT_W{1'b0}};
    assign bus.squash_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: stimulus pushes expected responses, monitor compares.
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    localparam int unsigned CntW = 32;

    typedef struct {
        logic     nrst;
        logic     ihit;
        logic     dhit;
        logic     dren;
        logic     dwen;
        logic     idex_dren;
        regbits_t rd;
        regbits_t rs;
        regbits_t rt;
        logic     br;
        logic     jmp;
        logic     hlt;
    } stim_t;

    typedef struct {
        logic [7:0]      ctl;
        logic            halt;
        logic [CntW-1:0] cyc;
        logic [CntW-1:0] stall;
        logic [CntW-1:0] squash;
    } exp_t;

    // Bit order: pc, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, exmem_fl, memwb_en
    localparam logic [7:0] Pc   = 8'h80;
    localparam logic [7:0] IfE  = 8'h40;
    localparam logic [7:0] IfF  = 8'h20;
    localparam logic [7:0] IdE  = 8'h10;
    localparam logic [7:0] IdF  = 8'h08;
    localparam logic [7:0] ExE  = 8'h04;
    localparam logic [7:0] ExF  = 8'h02;
    localparam logic [7:0] MwE  = 8'h01;
    localparam logic [7:0] AllE = Pc | IfE | IdE | ExE | MwE;

    logic CLK;
    logic nRST;

    pipeline_ctrl_if #(.REG_W(RegW), .CNT_W(CntW)) bus ();

    pipeline_ctrl #(.REG_W(RegW), .CNT_W(CntW)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: pipeline is either flowing, parked on a data miss, or stopped.
    logic            m_waiting = 1'b0;
    logic            m_stopped = 1'b0;
    logic [CntW-1:0] m_cyc = '0;
    logic [CntW-1:0] m_stall = '0;
    logic [CntW-1:0] m_squash = '0;

    function automatic stim_t idle();
        stim_t s;
        s.nrst = 1'b1; s.ihit = 1'b1; s.dhit = 1'b1;
        s.dren = 1'b0; s.dwen = 1'b0; s.idex_dren = 1'b0;
        s.rd = '0; s.rs = '0; s.rt = '0;
        s.br = 1'b0; s.jmp = 1'b0; s.hlt = 1'b0;
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        logic mem;
        logic dep;
        logic stop_after;
        logic [7:0] c;
        nRST             = s.nrst;
        bus.ihit         = s.ihit;
        bus.dhit         = s.dhit;
        bus.exmem_dREN   = s.dren;
        bus.exmem_dWEN   = s.dwen;
        bus.idex_dREN    = s.idex_dren;
        bus.idex_regDst  = s.rd;
        bus.ifid_rs      = s.rs;
        bus.ifid_rt      = s.rt;
        bus.branch_taken = s.br;
        bus.jump         = s.jmp;
        bus.halt_mem     = s.hlt;

        mem = s.dren | s.dwen;
        dep = s.idex_dren && s.rd != 0 && (s.rd == s.rs || s.rd == s.rt);
        stop_after = 1'b0;
        if (!s.nrst) begin
            m_waiting = 1'b0; m_stopped = 1'b0;
            m_cyc = '0; m_stall = '0; m_squash = '0;
            c = IfF | IdF | ExF;
        end else if (m_stopped) begin
            c = 8'h00;
        end else if (m_waiting && !s.dhit) begin
            c = 8'h00;
        end else if (mem && !s.dhit) begin
            c = 8'h00;
            m_waiting = 1'b1;
        end else begin
            m_waiting = 1'b0;
            if (mem && !s.ihit)  c = MwE | ExF;
            else if (!s.ihit)    c = 8'h00;
            else if (s.hlt)      begin c = MwE; stop_after = 1'b1; end
            else if (s.br)       c = AllE | IfF | IdF;
            else if (dep)        c = IdF | ExE | MwE;
            else if (s.jmp)      c = AllE | IfF;
            else                 c = AllE;
        end

        e.ctl  = c;
        e.halt = s.nrst ? m_stopped : 1'b0;
`ifdef PIPE_PERF_EN
        e.cyc = m_cyc; e.stall = m_stall; e.squash = m_squash;
`else
        e.cyc = '0; e.stall = '0; e.squash = '0;
`endif
        sb.push_back(e);

        if (s.nrst && !m_stopped) begin
            m_cyc = m_cyc + 1;
            if ((c & Pc) == 0) m_stall = m_stall + 1;
            if ((c & IfF) != 0) m_squash = m_squash + 1;
        end
        if (stop_after) m_stopped = 1'b1;

        @(posedge CLK);
        #1;
    endtask

    // Monitor: compare whatever the DUT presents mid-cycle against the oldest expectation.
    initial begin
        exp_t e;
        logic [7:0] got;
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                got = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_flush,
                       bus.exmem_en, bus.exmem_flush, bus.memwb_en};
                n_checks++;
                if (got !== e.ctl || bus.halt !== e.halt) begin
                    n_errors++;
                    $display("FAIL ctl t=%0t got ctl=%b halt=%b want ctl=%b halt=%b",
                             $time, got, bus.halt, e.ctl, e.halt);
                end
                n_checks++;
                if (bus.cyc_cnt !== e.cyc || bus.stall_cnt !== e.stall ||
                    bus.squash_cnt !== e.squash) begin
                    n_errors++;
                    $display("FAIL counters t=%0t got %0d/%0d/%0d want %0d/%0d/%0d", $time,
                             bus.cyc_cnt, bus.stall_cnt, bus.squash_cnt,
                             e.cyc, e.stall, e.squash);
                end
            end
        end
    end

    initial begin
        stim_t s;
        stim_t rst;
        int    budget;
        nRST = 1'b0;
        s = idle();
        bus.ihit = 1'b0; bus.dhit = 1'b0; bus.exmem_dREN = 1'b0; bus.exmem_dWEN = 1'b0;
        bus.idex_dREN = 1'b0; bus.idex_regDst = '0; bus.ifid_rs = '0; bus.ifid_rt = '0;
        bus.branch_taken = 1'b0; bus.jump = 1'b0; bus.halt_mem = 1'b0;
        @(posedge CLK);
        #1;
        rst = idle();
        rst.nrst = 1'b0;

        // Reset while parked on a data miss.
        step(rst);
        step(idle());
        s = idle(); s.dwen = 1'b1; s.dhit = 1'b0;
        step(s);
        step(s);
        step(rst);
        step(rst);
        step(idle());

        // Load-use on rt, then the same with r0 as destination.
        s = idle(); s.idex_dren = 1'b1; s.rd = 5'd5; s.rt = 5'd5; s.rs = 5'd3;
        step(s);
        step(idle());
        s.rd = 5'd0; s.rt = 5'd0;
        step(s);
        step(idle());

        // Store miss held three cycles, then data returns while fetch stalls.
        step(rst);
        s = idle(); s.dwen = 1'b1; s.dhit = 1'b0;
        step(s);
        step(s);
        step(s);
        s.dhit = 1'b1; s.ihit = 1'b0;
        step(s);
        step(idle());
        step(idle());

        // Branch, load-use and jump together.
        s = idle(); s.br = 1'b1; s.jmp = 1'b1; s.idex_dren = 1'b1; s.rd = 5'd7; s.rs = 5'd7;
        step(s);
        step(idle());

        // Halt, then confirm everything stays frozen.
        s = idle(); s.hlt = 1'b1;
        step(s);
        for (int i = 0; i < 4; i++) step(idle());
        step(rst);

        // Randomized traffic with occasional resets and halts.
        for (int i = 0; i < 3000; i++) begin
            s.nrst      = ($urandom_range(99) != 0);
            s.ihit      = ($urandom_range(3) != 0);
            s.dhit      = ($urandom_range(2) != 0);
            s.dren      = ($urandom_range(4) == 0);
            s.dwen      = ($urandom_range(5) == 0);
            s.idex_dren = ($urandom_range(2) == 0);
            s.rd        = regbits_t'($urandom_range(7));
            s.rs        = regbits_t'($urandom_range(7));
            s.rt        = regbits_t'($urandom_range(7));
            s.br        = ($urandom_range(7) == 0);
            s.jmp       = ($urandom_range(7) == 0);
            s.hlt       = ($urandom_range(63) == 0);
            step(s);
        end

        budget = 10;
        while (sb.size() > 0 && budget > 0) begin
            @(posedge CLK);
            budget--;
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain left=%0d want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
